// File: rtl/ahb2sram.sv
`default_nettype none
// ============================================================================
// Module   : ahb2sram
// Brief    : AHB-Lite slave bridging to a single-port synchronous SRAM.
//            Reads are zero-wait (SRAM read launched in the address phase).
//            Writes go through a one-entry write buffer that drains on any
//            cycle without a competing read. Reads see buffered bytes
//            through forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module ahb2sram #(
  parameter int BW_HADDR = 32,
  parameter int BW_HDATA = 32,
  parameter int MEM_AW   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ahb_hsel,
  input  logic                ahb_hready,
  input  logic [1:0]          ahb_htrans,
  input  logic                ahb_hwrite,
  input  logic [BW_HADDR-1:0] ahb_haddr,
  input  logic [2:0]          ahb_hsize,
  input  logic [2:0]          ahb_hburst,
  input  logic [3:0]          ahb_hprot,
  input  logic                ahb_hmastlock,
  input  logic [BW_HDATA-1:0] ahb_hwdata,
  output logic                ahb_hreadyout,
  output logic                ahb_hresp,
  output logic [BW_HDATA-1:0] ahb_hrdata,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [3:0]          sram_be,
  output logic [MEM_AW-1:0]   sram_addr,
  output logic [BW_HDATA-1:0] sram_wdata,
  input  logic [BW_HDATA-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Write buffer and registered address-phase information
  logic                buf_valid;
  logic [MEM_AW-1:0]   buf_addr;
  logic [3:0]          buf_be;
  logic [BW_HDATA-1:0] buf_data;
  logic [MEM_AW-1:0]   wr_addr;
  logic [3:0]          wr_be;
  logic [MEM_AW-1:0]   rd_addr;

  logic                ready;
  logic                accept;
  logic                size_bad;
  logic                align_bad;
  logic                range_bad;
  logic                illegal;
  logic                legal_rd;
  logic                legal_wr;
  logic                capture;
  logic                drain;
  logic [BW_HADDR-1:0] addr_hi;
  logic [MEM_AW-1:0]   word_addr;
  logic [3:0]          be_calc;
  logic [BW_HDATA-1:0] rd_merged;

  // Burst, protection and lock carry no meaning for a plain SRAM.
  logic unused_ok;
  assign unused_ok = ^{ahb_hburst, ahb_hprot, ahb_hmastlock, ahb_htrans[0]};

  // Wait states come only from registered state: ERR1, or a write data
  // phase that finds the buffer still occupied.
  assign ready = ~((state == S_ERR1) | ((state == S_WR) & buf_valid));
  assign ahb_hreadyout = ready;
  assign ahb_hresp     = (state == S_ERR1) | (state == S_ERR2);

  // Our own ready is folded in so a stalled cycle can never launch a
  // read that would block the pending drain.
  assign accept    = ahb_hsel & ahb_hready & ahb_htrans[1] & ready;
  assign addr_hi   = ahb_haddr >> (MEM_AW + 2);
  assign size_bad  = (ahb_hsize > 3'd2);
  assign align_bad = ((ahb_hsize == 3'd1) & ahb_haddr[0]) |
                     ((ahb_hsize == 3'd2) & (ahb_haddr[1:0] != 2'b00));
  assign range_bad = |addr_hi;
  assign illegal   = size_bad | align_bad | range_bad;
  assign legal_rd  = accept & ~illegal & ~ahb_hwrite;
  assign legal_wr  = accept & ~illegal & ahb_hwrite;
  assign word_addr = ahb_haddr[MEM_AW+1:2];

  assign capture = (state == S_WR) & ~buf_valid;
  assign drain   = buf_valid & ~legal_rd;

  // Byte lanes touched by the current address phase
  always_comb begin
    be_calc = 4'b0000;
    case (ahb_hsize)
      3'd0:    be_calc = 4'b0001 << ahb_haddr[1:0];
      3'd1:    be_calc = ahb_haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
  end

  // Data-phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a completed data phase picks up whatever was accepted
  always_comb begin
    state_nxt = state;
    if (ready) begin
      if (accept) begin
        if (illegal) begin
          state_nxt = S_ERR1;
        end else if (ahb_hwrite) begin
          state_nxt = S_WR;
        end else begin
          state_nxt = S_RD;
        end
      end else begin
        state_nxt = S_IDLE;
      end
    end else if (state == S_ERR1) begin
      state_nxt = S_ERR2;
    end
  end

  // Address-phase capture of write target and read word address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_be   <= '0;
      rd_addr <= '0;
    end else begin
      if (legal_wr) begin
        wr_addr <= word_addr;
        wr_be   <= be_calc;
      end
      if (legal_rd) begin
        rd_addr <= word_addr;
      end
    end
  end

  // Write buffer: a capture wins over a drain in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_be    <= '0;
      buf_data  <= '0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_addr  <= wr_addr;
      buf_be    <= wr_be;
      buf_data  <= ahb_hwdata;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // SRAM port: reads have priority, otherwise drain the buffer
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (legal_rd) begin
      sram_cs   = 1'b1;
      sram_addr = word_addr;
    end else if (buf_valid) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = buf_be;
      sram_addr  = buf_addr;
      sram_wdata = buf_data;
    end
  end

  // Read data with forwarding of bytes still sitting in the buffer
  always_comb begin
    rd_merged = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (buf_valid && (buf_addr == rd_addr) && buf_be[i]) begin
        rd_merged[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
  end

  assign ahb_hrdata = (state == S_RD) ? rd_merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb2sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb2sram
// Brief    : Self-checking bench for ahb2sram: directed scenarios followed
//            by randomized traffic against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hready, hwrite, hmastlock;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hreadyout, hresp;
  logic        sram_cs, sram_we;
  logic [3:0]  sram_be;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  // Single-slave system: the bus ready is this slave's own ready
  assign hready = hreadyout;

  ahb2sram #(.BW_HADDR(32), .BW_HDATA(32), .MEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahb_hsel(hsel), .ahb_hready(hready), .ahb_htrans(htrans),
    .ahb_hwrite(hwrite), .ahb_haddr(haddr), .ahb_hsize(hsize),
    .ahb_hburst(hburst), .ahb_hprot(hprot), .ahb_hmastlock(hmastlock),
    .ahb_hwdata(hwdata), .ahb_hreadyout(hreadyout), .ahb_hresp(hresp),
    .ahb_hrdata(hrdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Synchronous SRAM behaviour plus access counters
  logic [31:0] smem [0:4095];
  int          cs_cnt = 0;
  int          we_cnt = 0;
  logic [3:0]  last_be;
  logic [11:0] last_addr;
  always @(posedge clk) begin
    if (sram_cs) begin
      cs_cnt = cs_cnt + 1;
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) smem[sram_addr][8*i +: 8] = sram_wdata[8*i +: 8];
        we_cnt    = we_cnt + 1;
        last_be   = sram_be;
        last_addr = sram_addr;
      end else begin
        sram_rdata <= smem[sram_addr];
      end
    end
  end

  // Reference memory: state as an AHB master would see it
  logic [31:0] gm [0:4095];

  int ncmp = 0;
  int nfail = 0;

  // Pending data phase: 0 none, 1 read, 2 write, 3 error
  int          pk;
  logic [31:0] pa, pw;
  logic [2:0]  ps;
  int          last_waits;
  logic [31:0] last_rdata;
  logic        last_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    if ((a % (32'd1 << sz)) != 0) return 1'b0;
    if (a >= 32'h4000) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int b;
    for (int i = 0; i < (1 << sz); i++) begin
      b = int'(a % 4) + i;
      gm[a >> 2][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // One AHB cycle-group: present an address phase, complete the pending
  // data phase (absorbing any wait states), then record the new phase.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int waits;
    bit done;
    hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = pw;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (hreadyout !== 1'b1) begin
        waits++;
        if (pk == 3) chk("err1_resp", 32'(hresp), 32'd1);
        else if (pk != 2) chk("unexpected_wait", 32'(hreadyout), 32'd1);
        if (waits > 3) begin
          chk("wait_bound", 32'(waits), 32'd3);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end else begin
        last_rdata = hrdata;
        last_cs    = sram_cs;
        case (pk)
          1: begin
            chk("rd_data", hrdata, gm[pa[13:2]]);
            chk("rd_resp", 32'(hresp), 32'd0);
          end
          2: begin
            chk("wr_resp", 32'(hresp), 32'd0);
            chk("wr_waits_le1", 32'(waits <= 1), 32'd1);
            model_write(pa, ps, pw);
          end
          3: begin
            chk("err2_resp", 32'(hresp), 32'd1);
            chk("err_waits", 32'(waits), 32'd1);
          end
          default: begin
            chk("idle_resp", 32'(hresp), 32'd0);
            chk("idle_rdata", hrdata, 32'd0);
          end
        endcase
        done = 1'b1;
      end
    end
    last_waits = waits;
    @(posedge clk); #1;
    if (sel && tr[1]) begin
      pa = a; ps = sz; pw = wd;
      pk = !legal(a, sz) ? 3 : (wr ? 2 : 1);
    end else begin
      pk = 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] old, a;
    int w0, c0, sumw, r, word, sz, off;
    logic [2:0] szl;

    rst_n = 1'b0;
    hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 0; hwdata = 0;
    hburst = 0; hprot = 0; hmastlock = 0;
    pk = 0; pa = 0; pw = 0; ps = 0;
    for (int i = 0; i < 4096; i++) begin
      smem[i] = $urandom;
      gm[i]   = smem[i];
    end

    // Reset state
    @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_sram_cs", 32'(sram_cs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word write then idles: drain of the full word at word address 4
    step(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hA5A5_5A5A);
    idle();
    chk("wr_zero_wait", 32'(last_waits), 32'd0);
    w0 = we_cnt;
    idle();
    chk("drain_count", 32'(we_cnt), 32'(w0 + 1));
    chk("drain_be", 32'(last_be), 32'hF);
    chk("drain_addr", 32'(last_addr), 32'd4);
    chk("drain_mem", smem[4], 32'hA5A5_5A5A);

    // Byte write immediately followed by a read of the same word
    old = gm[4];
    step(1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hEE00_0000);
    step(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    w0 = we_cnt;
    idle();
    chk("fwd_word", last_rdata, {8'hEE, old[23:0]});
    chk("fwd_waits", 32'(last_waits), 32'd0);
    chk("fwd_drain_count", 32'(we_cnt), 32'(w0 + 1));
    chk("fwd_drain_be", 32'(last_be), 32'b1000);
    idle();

    // BUSY between reads
    step(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    step(1'b1, 2'b01, 1'b0, 32'h24, 3'd2, 32'h0);
    chk("busy_no_cs", 32'(last_cs), 32'd0);
    step(1'b1, 2'b10, 1'b0, 32'h24, 3'd2, 32'h0);
    chk("busy_dphase_rdata", last_rdata, 32'd0);
    idle();
    idle();

    // Reads then three back-to-back writes
    step(1'b1, 2'b10, 1'b0, 32'h30, 3'd2, 32'h0);
    step(1'b1, 2'b11, 1'b0, 32'h34, 3'd2, 32'h0);
    step(1'b1, 2'b10, 1'b1, 32'h0, 3'd2, $urandom);
    step(1'b1, 2'b11, 1'b1, 32'h4, 3'd2, $urandom);
    sumw = last_waits;
    step(1'b1, 2'b11, 1'b1, 32'h8, 3'd2, $urandom);
    sumw += last_waits;
    idle();
    sumw += last_waits;
    chk("b2b_waits", 32'(sumw), 32'd2);
    idle();
    idle();
    for (int i = 0; i < 3; i++) chk("b2b_mem", smem[i], gm[i]);

    // Illegal transfers: misaligned halfword, out-of-range word
    c0 = cs_cnt;
    step(1'b1, 2'b10, 1'b0, 32'h1, 3'd1, 32'h0);
    idle();
    step(1'b1, 2'b10, 1'b1, 32'h4000, 3'd2, 32'h1234_5678);
    idle();
    idle();
    chk("err_no_sram", 32'(cs_cnt), 32'(c0));

    // Reset while a write sits in the buffer
    old = gm[8];
    w0  = we_cnt;
    step(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, ~old);
    hsel = 0; htrans = 0; hwdata = pw;
    @(negedge clk);
    chk("pre_rst_ready", 32'(hreadyout), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pk = 0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(hreadyout), 32'd1);
    chk("mid_rst_cs", 32'(sram_cs), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_no_write", 32'(we_cnt), 32'(w0));
    step(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    idle();
    chk("rst_old_data", last_rdata, old);

    // Randomized traffic in a small window to exercise forwarding
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 99);
      word = $urandom_range(64, 79);
      sz   = $urandom_range(0, 2);
      off  = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      a    = 32'(word * 4 + off);
      szl  = 3'(sz);
      if (r < 35)      step(1'b1, 2'b10, 1'b0, a, szl, 32'h0);
      else if (r < 70) step(1'b1, 2'b11, 1'b1, a, szl, $urandom);
      else if (r < 78) step(1'b1, 2'b00, 1'b0, a, szl, 32'h0);
      else if (r < 84) step(1'b1, 2'b01, 1'b1, a, szl, $urandom);
      else if (r < 90) step(1'b0, 2'b10, 1'b1, a, szl, $urandom);
      else begin
        case ($urandom_range(0, 3))
          0:       step(1'b1, 2'b10, 1'($urandom), 32'(word * 4 + 1), 3'd1, $urandom);
          1:       step(1'b1, 2'b10, 1'($urandom), 32'(word * 4 + 2), 3'd2, $urandom);
          2:       step(1'b1, 2'b10, 1'($urandom), 32'(word * 4), 3'd3, $urandom);
          default: step(1'b1, 2'b10, 1'($urandom), 32'h4000 + 32'(word * 4), 3'd2, $urandom);
        endcase
      end
    end
    idle();
    idle();
    idle();
    for (int i = 64; i < 80; i++) chk("rand_mem", smem[i], gm[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
